// File: rtl/emsg_pkg.sv
// emsg_pkg: shared defaults, compressed-word layout and beat sizing for the check-node decompressor
package emsg_pkg;
   localparam int DEF_W = 6;
   localparam int DEF_WC = 32;
   localparam int DEF_LANES = 8;
   function automatic int cw(input int mw, input int deg);
      return 3 * (mw - 1) + deg;
   endfunction
   function automatic int min1_lsb(input int mw, input int deg);
      return deg + 2 * (mw - 1);
   endfunction
   function automatic int min2_lsb(input int mw, input int deg);
      return deg + (mw - 1);
   endfunction
   function automatic int pos_lsb(input int deg);
      return deg;
   endfunction
   function automatic int beats(input int deg, input int lanes);
      return deg / lanes;
   endfunction
   function automatic int beat_w(input int deg, input int lanes);
      return (deg / lanes > 1) ? $clog2(deg / lanes) : 1;
   endfunction
   localparam int CW = cw(DEF_W, DEF_WC);
   localparam int MIN1_LSB = min1_lsb(DEF_W, DEF_WC);
   localparam int MIN2_LSB = min2_lsb(DEF_W, DEF_WC);
   localparam int POS_LSB = pos_lsb(DEF_WC);
   localparam int SIGN_LSB = 0;
   localparam int BEATS = beats(DEF_WC, DEF_LANES);
   localparam int BEAT_W = beat_w(DEF_WC, DEF_LANES);
endpackage

// File: rtl/emsg_lane.sv
// emsg_lane: expands one edge of a compressed check-node word into a signed w-bit message
module emsg_lane
   import emsg_pkg::*;
#(
   parameter int w = DEF_W
) (
   input  logic [w-2:0] min1,
   input  logic [w-2:0] min2,
   input  logic [w-2:0] pos,
   input  logic [31:0]  idx,
   input  logic         sgn,
   output logic [w-1:0] msg
);
   logic [w-1:0] mag;
   assign mag = {1'b0, (idx == 32'(pos)) ? min2 : min1};
   assign msg = sgn ? -mag : mag;
endmodule

// File: rtl/emsg_decomp.sv
// emsg_decomp: streams compressed check-node words out as LANES edge messages per beat,
// with an active/pending word pair so consecutive words leave without bubbles
module emsg_decomp
   import emsg_pkg::*;
#(
   parameter int w = DEF_W,
   parameter int wc = DEF_WC,
   parameter int LANES = DEF_LANES,
   parameter int CW = cw(w, wc)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [CW-1:0]           in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [LANES*w-1:0]      out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [beat_w(wc, LANES)-1:0] out_beat,
   output logic                    out_last
);
   localparam int BEATS = beats(wc, LANES);
   localparam int BEAT_W = beat_w(wc, LANES);
   localparam int MIN1_LSB = min1_lsb(w, wc);
   localparam int MIN2_LSB = min2_lsb(w, wc);
   localparam int POS_LSB = pos_lsb(wc);
   if (wc % LANES != 0) begin : g_bad_lanes
      $error("emsg_decomp: wc must be a multiple of LANES");
   end
   logic              act_vld, pend_vld, accept, xfer, last_xfer;
   logic [BEAT_W-1:0] beat;
   logic [CW-1:0]     act_data, pend_data;
   logic [wc-1:0]     sgn_sh;
   assign in_ready  = !pend_vld && !rst;
   assign accept    = in_valid && in_ready;
   assign out_valid = act_vld;
   assign out_beat  = beat;
   assign out_last  = act_vld && (beat == BEAT_W'(BEATS - 1));
   assign xfer      = act_vld && out_ready;
   assign last_xfer = xfer && out_last;
   assign sgn_sh    = act_data[SIGN_LSB +: wc] >> (int'(beat) * LANES);
   // PEND only fills while ACT is busy, so a refill of ACT never coincides with an accept into PEND
   always_ff @(posedge clk) begin
      if (rst) begin
         act_vld   <= 1'b0;
         pend_vld  <= 1'b0;
         beat      <= '0;
         act_data  <= '0;
         pend_data <= '0;
      end else begin
         if (xfer) beat <= last_xfer ? '0 : beat + BEAT_W'(1);
         if (!act_vld || last_xfer) begin
            act_vld  <= pend_vld || accept;
            act_data <= pend_vld ? pend_data : accept ? in_data : act_data;
            pend_vld <= 1'b0;
         end else if (accept) begin
            pend_vld  <= 1'b1;
            pend_data <= in_data;
         end
      end
   end
   for (genvar k = 0; k < LANES; k++) begin : g_lane
      emsg_lane #(.w(w)) u_lane (
         .min1(act_data[MIN1_LSB +: w-1]),
         .min2(act_data[MIN2_LSB +: w-1]),
         .pos (act_data[POS_LSB +: w-1]),
         .idx (int'(beat) * LANES + k),
         .sgn (sgn_sh[k]),
         .msg (out_data[k*w +: w])
      );
   end
endmodule

// File: tb/tb_emsg_decomp.sv
// tb_emsg_decomp: scenario tasks plus a scoreboard of expected beats filled on every accepted word
module tb_emsg_decomp;
   logic        clk = 0, rst = 1, in_valid = 0, in_ready, out_valid, out_ready = 1, out_last;
   logic [46:0] in_data = '0;
   logic [47:0] out_data;
   logic [1:0]  out_beat;
   int          checks = 0, errors = 0;
   typedef struct packed { logic [47:0] d; logic [1:0] b; logic l; } exp_t;
   exp_t q[$];
   exp_t e;

   emsg_decomp dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_beat(out_beat), .out_last(out_last)
   );

   always #5 clk = ~clk;

   function automatic logic [46:0] mk(input logic [4:0] m1, input logic [4:0] m2, input logic [4:0] p, input logic [31:0] s);
      return {m1, m2, p, s};
   endfunction

   function automatic logic [47:0] model(input logic [46:0] wd, input int b);
      logic [47:0] r;
      logic [5:0]  m;
      int          i;
      for (int k = 0; k < 8; k++) begin
         i = b * 8 + k;
         m = (i == int'(wd[36:32])) ? {1'b0, wd[41:37]} : {1'b0, wd[46:42]};
         r[k*6 +: 6] = wd[i] ? (~m + 6'd1) : m;
      end
      return r;
   endfunction

   always @(negedge clk) begin
      if (rst) q.delete();
      else begin
         if (out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected: data=%h beat=%0d, required no output", out_data, out_beat);
            end else begin
               e = q.pop_front();
               if ({out_data, out_beat, out_last} !== e) begin
                  errors++;
                  $display("FAIL sb_beat: data=%h beat=%0d last=%b, required data=%h beat=%0d last=%b",
                           out_data, out_beat, out_last, e.d, e.b, e.l);
               end
            end
         end
         if (in_valid && in_ready)
            for (int b = 0; b < 4; b++) q.push_back('{model(in_data, b), 2'(b), b == 3});
      end
   end

   task automatic send(input logic [46:0] d);
      int c;
      c = 0;
      in_data = d;
      in_valid = 1;
      @(negedge clk);
      while (in_ready !== 1 && c < 30) begin c++; @(negedge clk); end
      checks++;
      if (in_ready !== 1) begin errors++; $display("FAIL send_accept: in_ready=%b, required 1 within 30 cycles", in_ready); end
      @(posedge clk); #1;
   endtask

   task automatic wait_idle(input string nm);
      int c;
      c = 0;
      @(negedge clk);
      while ((q.size() != 0 || out_valid !== 0) && c < 60) begin c++; @(negedge clk); end
      checks++;
      if (q.size() != 0 || out_valid !== 0) begin
         errors++;
         $display("FAIL %s_drain: pending=%0d out_valid=%b, required 0 and 0", nm, q.size(), out_valid);
      end
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      checks++; if ({out_valid, out_last, in_ready} !== 3'b000) begin errors++; $display("FAIL rst_flags: valid/last/ready=%b, required 000", {out_valid, out_last, in_ready}); end
      checks++; if (out_beat !== 2'd0) begin errors++; $display("FAIL rst_beat: got %0d, required 0", out_beat); end
      checks++; if (out_data !== 48'd0) begin errors++; $display("FAIL rst_data: got %h, required 0", out_data); end
      @(posedge clk); #1;
      rst = 0;
      @(negedge clk);
      checks++; if (in_ready !== 1) begin errors++; $display("FAIL rst_ready_after: got %b, required 1", in_ready); end
      checks++; if (out_valid !== 0) begin errors++; $display("FAIL rst_valid_after: got %b, required 0", out_valid); end
   endtask

   task automatic test_basic;
      @(posedge clk); #1;
      send(mk(5'd3, 5'd7, 5'd10, 32'h0000_0401));
      in_valid = 0;
      @(negedge clk);
      checks++; if (out_valid !== 1 || out_beat !== 0 || out_last !== 0 || out_data !== {{7{6'h03}}, 6'h3D}) begin errors++; $display("FAIL basic_beat0: v=%b beat=%0d last=%b data=%h, required 1 0 0 %h", out_valid, out_beat, out_last, out_data, {{7{6'h03}}, 6'h3D}); end
      @(negedge clk);
      checks++; if (out_beat !== 1 || out_data !== {{5{6'h03}}, 6'h39, {2{6'h03}}}) begin errors++; $display("FAIL basic_beat1: beat=%0d data=%h, required 1 %h", out_beat, out_data, {{5{6'h03}}, 6'h39, {2{6'h03}}}); end
      @(negedge clk);
      checks++; if (out_beat !== 2 || out_last !== 0 || out_data !== {8{6'h03}}) begin errors++; $display("FAIL basic_beat2: beat=%0d last=%b data=%h, required 2 0 %h", out_beat, out_last, out_data, {8{6'h03}}); end
      @(negedge clk);
      checks++; if (out_beat !== 3 || out_last !== 1 || out_data !== {8{6'h03}}) begin errors++; $display("FAIL basic_beat3: beat=%0d last=%b data=%h, required 3 1 %h", out_beat, out_last, out_data, {8{6'h03}}); end
      wait_idle("basic");
   endtask

   task automatic test_back_to_back;
      int cnt, first, last;
      cnt = 0; first = -1; last = -1;
      @(posedge clk); #1;
      fork
         begin
            send(mk(5'd1, 5'd2, 5'd3, 32'hA5A5_0F0F));
            send(mk(5'd15, 5'd4, 5'd17, 32'h1234_5678));
            send(mk(5'd9, 5'd0, 5'd30, 32'hFFFF_0000));
            in_valid = 0;
         end
         for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (out_valid === 1) begin if (first < 0) first = c; last = c; cnt++; end
         end
      join
      checks++; if (cnt != 12 || last - first != 11) begin errors++; $display("FAIL b2b_gapless: valid cycles=%0d span=%0d, required 12 and 12", cnt, last - first + 1); end
      wait_idle("b2b");
   endtask

   task automatic test_backpressure;
      logic [47:0] snap;
      logic [46:0] wa, wb, wcw;
      wa = mk(5'd6, 5'd2, 5'd20, 32'h00F0_0F00);
      wb = mk(5'd11, 5'd12, 5'd5, 32'hC000_0003);
      wcw = mk(5'd31, 5'd30, 5'd8, 32'h5555_AAAA);
      @(posedge clk); #1;
      send(wa);
      in_valid = 0;
      for (int i = 0; i < 10 && out_beat !== 2; i++) begin @(posedge clk); #1; end
      checks++; if (out_beat !== 2) begin errors++; $display("FAIL bp_reach_beat2: beat=%0d, required 2", out_beat); end
      out_ready = 0;
      snap = out_data;
      checks++; if (snap !== model(wa, 2)) begin errors++; $display("FAIL bp_beat2_data: got %h, required %h", snap, model(wa, 2)); end
      send(wb);
      in_data = wcw;
      in_valid = 1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++; if (out_valid !== 1 || out_beat !== 2 || out_last !== 0 || out_data !== snap) begin errors++; $display("FAIL bp_freeze: v=%b beat=%0d last=%b data=%h, required 1 2 0 %h", out_valid, out_beat, out_last, out_data, snap); end
         checks++; if (in_ready !== 0) begin errors++; $display("FAIL bp_stall: in_ready=%b, required 0", in_ready); end
      end
      @(posedge clk); #1;
      out_ready = 1;
      for (int i = 0; i < 20; i++) begin @(negedge clk); if (in_ready === 1) break; end
      checks++; if (in_ready !== 1) begin errors++; $display("FAIL bp_release: in_ready=%b, required 1", in_ready); end
      @(posedge clk); #1;
      in_valid = 0;
      wait_idle("bp");
   endtask

   task automatic test_boundary;
      logic [46:0] wd[3];
      logic [47:0] ex[3];
      int          bt[3];
      wd[0] = mk(5'd0, 5'd5, 5'd4, '1);               bt[0] = 0; ex[0] = {{3{6'h00}}, 6'h3B, {4{6'h00}}};
      wd[1] = mk(5'd1, 5'd31, 5'd31, 32'h8000_0000);  bt[1] = 3; ex[1] = {6'h21, {7{6'h01}}};
      wd[2] = mk(5'd2, 5'd9, 5'd0, 32'h0000_0001);    bt[2] = 0; ex[2] = {{7{6'h02}}, 6'h37};
      for (int j = 0; j < 3; j++) begin
         @(posedge clk); #1;
         send(wd[j]);
         in_valid = 0;
         for (int c = 0; c < 8; c++) begin @(negedge clk); if (out_valid === 1 && out_beat === 2'(bt[j])) break; end
         checks++; if (out_valid !== 1 || out_beat !== 2'(bt[j]) || out_data !== ex[j]) begin errors++; $display("FAIL bound_%0d: v=%b beat=%0d data=%h, required 1 %0d %h", j, out_valid, out_beat, out_data, bt[j], ex[j]); end
         wait_idle("bound");
      end
   endtask

   task automatic test_simul;
      logic [46:0] wa, wb;
      wa = mk(5'd4, 5'd8, 5'd12, 32'h0F0F_F0F0);
      wb = mk(5'd13, 5'd1, 5'd1, 32'h8421_8421);
      @(posedge clk); #1;
      send(wa);
      in_valid = 0;
      for (int i = 0; i < 10 && out_last !== 1; i++) begin @(posedge clk); #1; end
      checks++; if (out_last !== 1) begin errors++; $display("FAIL simul_last: out_last=%b, required 1", out_last); end
      in_data = wb;
      in_valid = 1;
      @(negedge clk);
      checks++; if (in_ready !== 1) begin errors++; $display("FAIL simul_ready: in_ready=%b, required 1", in_ready); end
      @(posedge clk); #1;
      in_valid = 0;
      @(negedge clk);
      checks++; if (out_valid !== 1 || out_beat !== 0 || out_data !== model(wb, 0)) begin errors++; $display("FAIL simul_next: v=%b beat=%0d data=%h, required 1 0 %h", out_valid, out_beat, out_data, model(wb, 0)); end
      checks++; if (in_ready !== 1) begin errors++; $display("FAIL simul_pend_empty: in_ready=%b, required 1", in_ready); end
      wait_idle("simul");
   endtask

   task automatic test_mid_reset;
      logic [46:0] wn;
      wn = mk(5'd10, 5'd20, 5'd9, 32'h0000_0200);
      @(posedge clk); #1;
      send(mk(5'd7, 5'd3, 5'd2, 32'hDEAD_BEEF));
      send(mk(5'd8, 5'd9, 5'd25, 32'hCAFE_F00D));
      in_valid = 0;
      for (int i = 0; i < 10 && out_beat !== 1; i++) begin @(posedge clk); #1; end
      checks++; if (out_beat !== 1 || in_ready !== 0) begin errors++; $display("FAIL mrst_setup: beat=%0d in_ready=%b, required 1 0", out_beat, in_ready); end
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      @(negedge clk);
      checks++; if (out_valid !== 0 || out_beat !== 0 || out_data !== 48'd0) begin errors++; $display("FAIL mrst_cleared: v=%b beat=%0d data=%h, required 0 0 0", out_valid, out_beat, out_data); end
      checks++; if (in_ready !== 1) begin errors++; $display("FAIL mrst_ready: in_ready=%b, required 1", in_ready); end
      @(posedge clk); #1;
      send(wn);
      in_valid = 0;
      @(negedge clk);
      checks++; if (out_valid !== 1 || out_beat !== 0 || out_data !== model(wn, 0)) begin errors++; $display("FAIL mrst_fresh: v=%b beat=%0d data=%h, required 1 0 %h", out_valid, out_beat, out_data, model(wn, 0)); end
      wait_idle("mrst");
   endtask

   initial begin
      test_reset;
      test_basic;
      test_back_to_back;
      test_backpressure;
      test_boundary;
      test_simul;
      test_mid_reset;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at 200000, required completion");
      $fatal(1, "watchdog expired");
   end
endmodule
